// File: rtl/bcd_convert_arbiter.sv
// ============================================================================
// Module   : bcd_convert_arbiter
// Brief    : Round-robin sharing of one 8-bit binary-to-BCD converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd (
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o
);

  logic [19:0] w_shift;

  // Double-dabble: add 3 to any digit >= 5 before each shift.
  always_comb begin
    w_shift = {12'd0, bin_i};
    for (int k = 0; k < 8; k++) begin
      if (w_shift[11:8]  > 4'd4) w_shift[11:8]  = w_shift[11:8]  + 4'd3;
      if (w_shift[15:12] > 4'd4) w_shift[15:12] = w_shift[15:12] + 4'd3;
      if (w_shift[19:16] > 4'd4) w_shift[19:16] = w_shift[19:16] + 4'd3;
      w_shift = w_shift << 1;
    end
    bcd_o = w_shift[19:8];
  end

endmodule

module bcd_convert_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_i,
  input  logic [8*NREQ-1:0]   bin_in_i,
  output logic [NREQ-1:0]     ack_o,
  output logic [NREQ-1:0]     done_o,
  output logic [11:0]         bcd_out_o,
  output logic [2:0]          grant_id_o,
  output logic                busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [7:0]      opnd_q, opnd_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [2:0]      gid_q, gid_d;
  logic            busy_q, busy_d;

  logic [7:0]      w_req_pad;
  logic [63:0]     w_bin_pad;
  logic            w_found;
  logic [2:0]      w_winner;
  logic [11:0]     w_bcd;

  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int unsigned off);
    logic [3:0] s;
    s = {1'b0, base} + 4'(off);
    if (s >= 4'(NREQ)) s = s - 4'(NREQ);
    return s[2:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] sel);
    logic [7:0] t;
    t = 8'd1 << sel;
    return t[NREQ-1:0];
  endfunction

  bin2bcd u_bin2bcd (
    .bin_i (opnd_q),
    .bcd_o (w_bcd)
  );

  // Padding to 8 requesters keeps 3-bit indices in range for any legal NREQ.
  assign w_req_pad = 8'(req_i);
  assign w_bin_pad = 64'(bin_in_i);

  always_comb begin
    w_found  = 1'b0;
    w_winner = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_req_pad[wrap_add(ptr_q, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(ptr_q, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      opnd_q  <= 8'd0;
      ack_q   <= '0;
      done_q  <= '0;
      bcd_q   <= 12'h000;
      gid_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      opnd_q  <= opnd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_found) state_d = S_LOAD;
      S_LOAD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    opnd_d = opnd_q;
    ack_d  = '0;
    done_d = '0;
    bcd_d  = bcd_q;
    gid_d  = gid_q;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          opnd_d = w_bin_pad[{w_winner, 3'b000} +: 8];
          gid_d  = w_winner;
          ack_d  = onehot(w_winner);
        end
      end
      S_LOAD: begin
        bcd_d  = w_bcd;
        done_d = onehot(gid_q);
      end
      S_DONE:  ptr_d = wrap_add(gid_q, 1);
      default: ;
    endcase
  end

  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign bcd_out_o  = bcd_q;
  assign grant_id_o = gid_q;
  assign busy_o     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_convert_arbiter.sv
// ============================================================================
// Module   : tb_bcd_convert_arbiter
// Brief    : Scoreboard bench for the shared BCD converter arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_convert_arbiter;

  localparam int NREQ = 4;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   bin_in;
  logic [NREQ-1:0]     ack_o;
  logic [NREQ-1:0]     done_o;
  logic [11:0]         bcd_out_o;
  logic [2:0]          grant_id_o;
  logic                busy_o;

  bcd_convert_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .bin_in_i   (bin_in),
    .ack_o      (ack_o),
    .done_o     (done_o),
    .bcd_out_o  (bcd_out_o),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [11:0] bcd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [NREQ-1:0] hold;

  function automatic logic [11:0] bcd_ref(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decimal-digit and round-robin model, checked every cycle.
  initial begin
    logic [NREQ-1:0] r, exp_ack, exp_done;
    logic [11:0]     last_bcd;
    logic [2:0]      last_gid;
    int cyc, next_free, mptr, infl, infl_due, w, pos;
    last_bcd = '0; last_gid = '0;
    cyc = 0; next_free = 0; mptr = 0; infl = -1; infl_due = 0;
    forever begin
      @(posedge clk);
      r = req;
      #1;
      cyc++;
      if (!rst_n) begin
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_bcd", 32'(bcd_out_o), 0);
        chk("rst_gid", 32'(grant_id_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        last_bcd = '0; last_gid = '0; next_free = 0; mptr = 0; infl = -1;
        sb.delete();
      end else begin
        exp_ack = '0;
        if (cyc >= next_free && r != '0) begin
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && r[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
          exp_ack[w] = 1'b1;
          infl = w; infl_due = cyc + 1; next_free = cyc + 3;
          mptr = (w + 1) % NREQ;
          last_gid = 3'(w);
        end
        chk("ack", 32'(ack_o), 32'(exp_ack));
        exp_done = '0;
        if (infl >= 0 && infl_due == cyc) begin
          exp_done[infl] = 1'b1;
          pos = -1;
          for (int k = 0; k < sb.size(); k++)
            if (pos < 0 && sb[k].idx == infl) pos = k;
          if (pos < 0) begin
            chk("sb_entry_present", 0, 1);
          end else begin
            last_bcd = sb[pos].bcd;
            sb.delete(pos);
          end
          infl = -1;
        end
        chk("done", 32'(done_o), 32'(exp_done));
        chk("bcd_out", 32'(bcd_out_o), 32'(last_bcd));
        chk("grant_id", 32'(grant_id_o), 32'(last_gid));
        chk("busy", 32'(busy_o), 32'(cyc < next_free - 1));
      end
    end
  end

  task automatic issue(input int i, input int op);
    bin_in[8*i +: 8] = 8'(op);
    req[i] = 1'b1;
    sb.push_back('{idx: i, bcd: bcd_ref(op)});
  endtask

  // Requesters drop on ack, or re-request at once when held.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (ack_o[i]) begin
        if (hold[i]) issue(i, int'($urandom_range(0, 255)));
        else begin
          req[i] = 1'b0;
          bin_in[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic wait_ack(input int i);
    int n = 0;
    do begin
      step();
      n++;
    end while (!ack_o[i] && n < 100);
    if (!ack_o[i]) chk("ack_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((req != '0 || sb.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; bin_in = '0; hold = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    // All four at once from ptr 0: served 0,1,2,3.
    issue(0, 10); issue(1, 99); issue(2, 200); issue(3, 0);
    drain();

    issue(0, 255);
    drain();

    // Continuous req[3] and req[0] must alternate.
    hold[3] = 1'b1; hold[0] = 1'b1;
    issue(3, 5); issue(0, 6);
    repeat (14) step();
    hold = '0;
    drain();

    for (int v = 0; v < 256; v++) begin
      issue(2, v);
      wait_ack(2);
    end
    drain();

    // Reset while the grant is in LOAD.
    issue(0, 77);
    wait_ack(0);
    rst_n = 1'b0;
    req = '0;
    step();
    rst_n = 1'b1;
    issue(1, 42);
    drain();

    issue(1, 37);
    wait_ack(1);
    bin_in[15:8] = 8'd200;
    drain();

    for (int i = 0; i < NREQ; i++) hold[i] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) issue(i, int'($urandom_range(0, 255)));
      if (c == 200) hold = '0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
